// File: rtl/pwm_sample_feeder.sv
// pwm_sample_feeder: gain, saturate and queue audio samples, emitting one per PWM frame; PWM_FEEDER_SAT_CNT_EN adds sat_count
module pwm_sample_feeder #(
  parameter int IN_WIDTH    = 12,
  parameter int OUT_WIDTH   = 12,
  parameter int COUNT_WIDTH = 10,
  parameter int FIFO_DEPTH  = 4,
  parameter int SHIFT_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [IN_WIDTH-1:0]    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic        [SHIFT_WIDTH-1:0] gain_shift,
  input  logic                          clr_flags,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic                          frame_tick,
  output logic                          overflow,
  output logic                          underrun
`ifdef PWM_FEEDER_SAT_CNT_EN
  ,
  output logic        [15:0]            sat_count
`endif
);
  localparam int EW = IN_WIDTH + (1 << SHIFT_WIDTH) - 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [EW-1:0] SMAX = EW'((1 << (COUNT_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] SMIN = ~SMAX;
  logic signed [COUNT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic [COUNT_WIDTH-1:0] frame_cnt;
  logic run, empty, full, push, pop, clip;
  logic signed [EW-1:0] shifted;
  logic signed [COUNT_WIDTH-1:0] sat;
  always_comb begin
    empty = wp == rp;
    full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    in_ready = !full;
    push = in_valid && !full;
    pop = run && &frame_cnt;
    shifted = EW'(in_data) <<< gain_shift;
    clip = shifted > SMAX || shifted < SMIN;
    sat = shifted > SMAX ? SMAX[COUNT_WIDTH-1:0] : shifted < SMIN ? SMIN[COUNT_WIDTH-1:0] : shifted[COUNT_WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run <= 1'b0;
      frame_cnt <= '0;
      frame_tick <= 1'b0;
      wp <= '0;
      rp <= '0;
      out_data <= '0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      run <= 1'b1;
      frame_cnt <= run ? frame_cnt + 1'b1 : '0;
      frame_tick <= !run || &frame_cnt;
      if (push) wp <= wp + 1'b1;
      if (pop && !empty) begin
        rp <= rp + 1'b1;
        out_data <= OUT_WIDTH'(mem[rp[AW-1:0]]);
      end
      overflow <= (in_valid && full) || (overflow && !clr_flags);
      underrun <= (pop && empty) || (underrun && !clr_flags);
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= sat;
`ifdef PWM_FEEDER_SAT_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sat_count <= '0;
    else if (clr_flags) sat_count <= {15'd0, push && clip};
    else if (push && clip && !(&sat_count)) sat_count <= sat_count + 1'b1;
`endif
endmodule
